// File: rtl/bcd_conv_pkg.sv
// Purpose : shared state encoding, sign-digit codes and nibble-correction helper
//           for the arbitrated binary-to-BCD converter.
// Latency : n/a (declarations only).   Backpressure: n/a.
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] SGN_MINUS = 4'hA;
    localparam logic [3:0] SGN_BLANK = 4'hF;

    // Double-dabble correction: a digit of 5..9 would overflow past 9 after
    // the doubling shift, so pre-add 3 to make it carry into the next digit.
    function automatic logic [3:0] dd_fix(input logic [3:0] nib);
        return (nib > 4'd4) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_dd_step.sv
// Purpose : one double-dabble iteration: correct every BCD digit, shift left 1,
//           insert the next operand bit at the bottom.
// Latency : combinational.   Backpressure: none.
// Ports   : bcd_i (current BCD register), bit_i (next operand bit, MSB-first),
//           bcd_o (next BCD register; the top bit shifted out is discarded).
module dd_step
    import bcd_conv_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [DIGITS*4-1:0] bcd_i,
    input  logic                bit_i,
    output logic [DIGITS*4-1:0] bcd_o
);

    logic [DIGITS*4-1:0] fixed;

    always_comb begin
        fixed = '0;
        for (int d = 0; d < DIGITS; d++) begin
            fixed[d*4 +: 4] = dd_fix(bcd_i[d*4 +: 4]);
        end
    end

    // Low digits never depend on higher ones, so dropping the carry out of the
    // top digit leaves exactly the low DIGITS decimal digits.
    assign bcd_o = {fixed[DIGITS*4-2:0], bit_i};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Purpose : round-robin arbiter in front of a serial (one bit per cycle)
//           binary-to-BCD converter with optional two's-complement magnitude/sign.
// Latency : done rises WIDTH+1 cycles after the edge that samples req; one
//           conversion per WIDTH+2 cycles. Backpressure: req is a level, sampled
//           only in IDLE; requesters wait (hold req) until granted.
// Ports   : clk, rst (sync, active-high); req[NREQ] / bin_in[NREQ*WIDTH] in;
//           gnt (one-hot, CONV only), busy, done (1-cycle pulse), done_id,
//           bcd_out (LS digit in [3:0]), bcd_sgn (A = minus, F = blank) out.
module bcd_conv_arbiter
    import bcd_conv_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int DIGITS  = 2,
    parameter int NREQ    = 4,
    parameter int ABS_VAL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     bin_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [DIGITS*4-1:0]       bcd_out,
    output logic [3:0]                bcd_sgn
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e              state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       cur_id_q;
    logic [IW-1:0]       done_id_q;
    logic [NREQ-1:0]     gnt_q;
    logic                done_q;
    logic [WIDTH-1:0]    op_q;
    logic [3:0]          sgn_q;
    logic [3:0]          bcd_sgn_q;
    logic [DIGITS*4-1:0] sh_q;
    logic [DIGITS*4-1:0] bcd_out_q;
    logic [CW-1:0]       cnt_q;

    logic                sel_vld_d;
    logic [IW-1:0]       sel_idx_d;
    logic [IW-1:0]       ptr_d;
    logic [WIDTH-1:0]    op_sel_d;
    logic [WIDTH-1:0]    op_load_d;
    logic [3:0]          sgn_load_d;
    logic [DIGITS*4-1:0] sh_d;
    int                  rr_idx;

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        sel_vld_d = 1'b0;
        sel_idx_d = '0;
        rr_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            rr_idx = int'(ptr_q) + i;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (!sel_vld_d && req[IW'(rr_idx)]) begin
                sel_vld_d = 1'b1;
                sel_idx_d = IW'(rr_idx);
            end
        end
    end

    assign ptr_d = (sel_idx_d == IW'(NREQ - 1)) ? '0 : (sel_idx_d + IW'(1));

    // Negative operands are stored as their magnitude; the most negative value
    // negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        op_sel_d   = bin_in[sel_idx_d*WIDTH +: WIDTH];
        op_load_d  = op_sel_d;
        sgn_load_d = SGN_BLANK;
        if ((ABS_VAL != 0) && op_sel_d[WIDTH-1]) begin
            op_load_d  = (~op_sel_d) + WIDTH'(1);
            sgn_load_d = SGN_MINUS;
        end
    end

    dd_step #(
        .DIGITS (DIGITS)
    ) u_dd_step (
        .bcd_i (sh_q),
        .bit_i (op_q[WIDTH-1]),
        .bcd_o (sh_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cur_id_q  <= '0;
            done_id_q <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            op_q      <= '0;
            sgn_q     <= SGN_BLANK;
            bcd_sgn_q <= SGN_BLANK;
            sh_q      <= '0;
            bcd_out_q <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_vld_d) begin
                        gnt_q    <= NREQ'(1) << sel_idx_d;
                        cur_id_q <= sel_idx_d;
                        ptr_q    <= ptr_d;
                        op_q     <= op_load_d;
                        sgn_q    <= sgn_load_d;
                        sh_q     <= '0;
                        cnt_q    <= '0;
                        state_q  <= CONV;
                    end
                end
                CONV: begin
                    sh_q  <= sh_d;
                    op_q  <= op_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    // Grant drops as the last bit is consumed so it is already
                    // low for the whole DONE cycle.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        gnt_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q    <= 1'b1;
                    bcd_out_q <= sh_q;
                    bcd_sgn_q <= sgn_q;
                    done_id_q <= cur_id_q;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign bcd_out = bcd_out_q;
    assign bcd_sgn = bcd_sgn_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Purpose : self-checking bench for bcd_conv_arbiter (scoreboard of expected
//           done results plus per-scenario inline checks).
// Latency : n/a.   Backpressure: n/a.
module tb_bcd_conv_arbiter;

    localparam int WIDTH  = 6;
    localparam int DIGITS = 2;
    localparam int NREQ   = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] bin_in;

    logic [NREQ-1:0]       gnt;
    logic                  busy, done;
    logic [1:0]            done_id;
    logic [7:0]            bcd_out;
    logic [3:0]            bcd_sgn;

    logic [NREQ-1:0]       gnt_u;
    logic                  busy_u, done_u;
    logic [1:0]            done_id_u;
    logic [7:0]            bcd_out_u;
    logic [3:0]            bcd_sgn_u;

    logic [NREQ-1:0]       gnt_t;
    logic                  busy_t, done_t;
    logic [1:0]            done_id_t;
    logic [3:0]            bcd_out_t;
    logic [3:0]            bcd_sgn_t;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .NREQ(NREQ), .ABS_VAL(1)) dut (
        .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(gnt), .busy(busy),
        .done(done), .done_id(done_id), .bcd_out(bcd_out), .bcd_sgn(bcd_sgn));

    bcd_conv_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .NREQ(NREQ), .ABS_VAL(0)) dut_u (
        .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(gnt_u), .busy(busy_u),
        .done(done_u), .done_id(done_id_u), .bcd_out(bcd_out_u), .bcd_sgn(bcd_sgn_u));

    bcd_conv_arbiter #(.WIDTH(WIDTH), .DIGITS(1), .NREQ(NREQ), .ABS_VAL(1)) dut_t (
        .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(gnt_t), .busy(busy_t),
        .done(done_t), .done_id(done_id_t), .bcd_out(bcd_out_t), .bcd_sgn(bcd_sgn_t));

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] bcd;
        logic [3:0] sgn;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    int   cyc    = 0;
    int   done_cyc[$];

    // Reference model: arithmetic magnitude and decimal digits by division.
    function automatic exp_t model(input logic [1:0] id, input logic [5:0] v,
                                   input bit absv, input int digits);
        exp_t e;
        int   mag;
        e.id  = id;
        e.sgn = 4'hF;
        e.bcd = '0;
        mag   = int'(v);
        if (absv && v[5]) begin
            mag   = 64 - int'(v);
            e.sgn = 4'hA;
        end
        for (int d = 0; d < digits; d++) begin
            e.bcd[d*4 +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: grant shape every cycle, scoreboard pop on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("FAIL gnt_onehot got %b", gnt);
            end
            if (done) begin
                n_done++;
                done_cyc.push_back(cyc);
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done id=%0d bcd=%h sgn=%h", done_id, bcd_out, bcd_sgn);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({done_id, bcd_out, bcd_sgn} !== mon_e) begin
                        errors++;
                        $display("FAIL scoreboard got id=%0d bcd=%h sgn=%h exp id=%0d bcd=%h sgn=%h",
                                 done_id, bcd_out, bcd_sgn, mon_e.id, mon_e.bcd, mon_e.sgn);
                    end
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        int n0;
        bit ok;
        n0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_done != n0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout got no done within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({gnt, busy, done, done_id, bcd_out, bcd_sgn} !== {4'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF}) begin
            errors++;
            $display("FAIL %s got gnt=%b busy=%b done=%b id=%0d bcd=%h sgn=%h exp 0000 0 0 0 00 f",
                     tag, gnt, busy, done, done_id, bcd_out, bcd_sgn);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req    = '0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_state");
        checks++;
        if (bcd_sgn_u !== 4'hF || bcd_out_t !== 4'h0) begin
            errors++;
            $display("FAIL reset_aux got sgn_u=%h bcd_t=%h exp f 0", bcd_sgn_u, bcd_out_t);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        @(posedge clk);
        #1;
        bin_in = {6'd0, 6'd0, 6'd0, 6'd25};
        req    = 4'b0001;
        sb_q.push_back(model(2'd0, 6'd25, 1'b1, 2));
        @(posedge clk);                 // sampling edge E0
        #1 req = '0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_grant got gnt=%b busy=%b done=%b exp 0001 1 0", gnt, busy, done);
        end
        repeat (5) @(posedge clk);      // E5: last CONV cycle
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold got gnt=%b done=%b exp 0001 0", gnt, done);
        end
        @(posedge clk);                 // E6: DONE state
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_state got gnt=%b busy=%b done=%b exp 0000 1 0", gnt, busy, done);
        end
        @(posedge clk);                 // E7 = E0 + WIDTH + 1
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency got done=%b busy=%b exp 1 0", done, busy);
        end
        checks++;
        if (bcd_out_u !== 8'h25 || bcd_sgn_u !== 4'hF || bcd_out_t !== 4'h5) begin
            errors++;
            $display("FAIL basic_aux got bcd_u=%h sgn_u=%h bcd_t=%h exp 25 f 5", bcd_out_u, bcd_sgn_u, bcd_out_t);
        end
    endtask

    task automatic test_negative();
        @(posedge clk);
        #1;
        bin_in = {6'd0, 6'd0, 6'b101101, 6'd0};
        req    = 4'b0010;
        sb_q.push_back(model(2'd1, 6'b101101, 1'b1, 2));
        @(posedge clk);
        #1 req = '0;
        wait_done(20);
        checks++;
        if (bcd_out_u !== 8'h45 || bcd_sgn_u !== 4'hF) begin
            errors++;
            $display("FAIL negative_unsigned got bcd=%h sgn=%h exp 45 f", bcd_out_u, bcd_sgn_u);
        end
    endtask

    task automatic test_most_negative();
        @(posedge clk);
        #1;
        bin_in = {6'd0, 6'b100000, 6'd0, 6'd0};
        req    = 4'b0100;
        sb_q.push_back(model(2'd2, 6'b100000, 1'b1, 2));
        @(posedge clk);
        #1 req = '0;
        wait_done(20);
        checks++;
        if (bcd_out_u !== 8'h32 || bcd_sgn_u !== 4'hF) begin
            errors++;
            $display("FAIL most_neg_unsigned got bcd=%h sgn=%h exp 32 f", bcd_out_u, bcd_sgn_u);
        end
        checks++;
        if (bcd_out_t !== 4'h2 || bcd_sgn_t !== 4'hA) begin
            errors++;
            $display("FAIL truncate got bcd=%h sgn=%h exp 2 a", bcd_out_t, bcd_sgn_t);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int n0;
        logic [5:0] ops [4];
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ops[0] = 6'd42;
        ops[1] = 6'd0;
        ops[2] = 6'b111111;
        ops[3] = 6'd63;
        bin_in = {ops[3], ops[2], ops[1], ops[0]};
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back(model(2'(k % 4), ops[k % 4], 1'b1, 2));
        end
        base = done_cyc.size();
        req  = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(20);
        end
        @(posedge clk);                 // samples the fifth grant
        #1 req = '0;
        wait_done(20);
        checks++;
        if (done_cyc.size() != base + 5) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 5", done_cyc.size() - base);
        end else begin
            for (int k = 1; k < 5; k++) begin
                checks++;
                if (done_cyc[base+k] - done_cyc[base+k-1] != 8) begin
                    errors++;
                    $display("FAIL b2b_spacing got %0d exp 8", done_cyc[base+k] - done_cyc[base+k-1]);
                end
            end
        end
        n0 = n_done;
        repeat (12) @(negedge clk);
        checks++;
        if (n_done != n0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_extra got extra=%0d pending=%0d exp 0 0", n_done - n0, sb_q.size());
        end
    endtask

    task automatic test_abort();
        int n0;
        @(posedge clk);
        #1;
        bin_in = {6'd0, 6'd17, 6'd0, 6'd0};
        req    = 4'b0100;
        @(posedge clk);                 // E0
        #1 req = '0;
        @(posedge clk);                 // E1
        @(posedge clk);                 // E2
        #1 rst = 1'b1;                  // sampled by E3, during the third CONV cycle
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("abort_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        n0 = n_done;
        repeat (10) @(negedge clk);
        checks++;
        if (n_done != n0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done pulses exp 0", n_done - n0);
        end
        // Pointer must restart at 0: requesters 0 and 3 both ask, 0 wins.
        @(posedge clk);
        #1;
        bin_in = {6'd33, 6'd0, 6'd0, 6'd9};
        req    = 4'b1001;
        sb_q.push_back(model(2'd0, 6'd9, 1'b1, 2));
        @(posedge clk);
        #1 req = '0;
        wait_done(20);
    endtask

    task automatic test_hold_change();
        int n0;
        @(posedge clk);
        #1;
        bin_in = {6'd0, 6'd0, 6'd0, 6'd13};
        req    = 4'b0001;
        sb_q.push_back(model(2'd0, 6'd13, 1'b1, 2));
        n0 = n_done;
        @(posedge clk);                 // E0
        @(posedge clk);
        @(posedge clk);
        #1;
        req    = '0;
        bin_in = {6'd0, 6'd0, 6'd0, 6'd50};
        wait_done(20);
        repeat (12) @(negedge clk);
        checks++;
        if (n_done != n0 + 1) begin
            errors++;
            $display("FAIL hold_once got %0d done pulses exp 1", n_done - n0);
        end
        checks++;
        if (bcd_out !== 8'h13 || done_id !== 2'd0 || bcd_sgn !== 4'hF || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_outputs got bcd=%h id=%0d sgn=%h busy=%b exp 13 0 f 0",
                     bcd_out, done_id, bcd_sgn, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_most_negative();
        test_back_to_back();
        test_abort();
        test_hold_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
